// File: rtl/wmem_pkg.sv
// wmem_pkg: engine states, skid depth and byte parity helper for mem_weight_stream
package wmem_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} wmem_state_e;
    localparam int SKID_DEPTH = 2;
    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction
endpackage

// File: rtl/wmem_skid_fifo.sv
// wmem_skid_fifo: 2-entry valid/ready FIFO; a pop frees space for a same-cycle push
module wmem_skid_fifo
    import wmem_pkg::*;
#(
    parameter int W = 65
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] dout,
    output logic [1:0]   level
);
    logic [W-1:0] buf_q [SKID_DEPTH];
    logic rptr, wptr, pop;
    assign valid = level != 2'd0;
    assign pop = valid & ready;
    assign dout = buf_q[rptr];
    always_ff @(posedge clk) begin
        if (rst) begin
            level <= '0;
            rptr <= 1'b0;
            wptr <= 1'b0;
            buf_q[0] <= '0;
            buf_q[1] <= '0;
        end else begin
            if (push) buf_q[wptr] <= din;
            wptr <= wptr ^ push;
            rptr <= rptr ^ pop;
            level <= level + 2'(push) - 2'(pop);
        end
    end
endmodule

// File: rtl/mem_weight_stream.sv
// mem_weight_stream: weight memory with host write port and burst-read stream engine; WMEM_PARITY_EN adds byte parity
module mem_weight_stream
    import wmem_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4096,
    parameter int AW = $clog2(DEPTH),
    parameter int LEN_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [31:0]        wr_addr,
    input  logic [WIDTH-1:0]   wr_data,
    input  logic [WIDTH/8-1:0] wr_be,
    input  logic               burst_start,
    input  logic [AW-1:0]      burst_base,
    input  logic [LEN_W-1:0]   burst_len,
    output logic               busy,
    output logic               done,
    output logic               rd_valid,
    input  logic               rd_ready,
    output logic [WIDTH-1:0]   rd_data,
    output logic               rd_last,
    output logic               par_err
);
    localparam int NB = WIDTH / 8;
    logic [WIDTH-1:0] mem [DEPTH];
    wmem_state_e state;
    logic [AW-1:0] addr;
    logic [LEN_W-1:0] len, issued;
    logic [WIDTH-1:0] rdword;
    logic [1:0] level;
    logic wr_ok, issue, pop, out_last, fifo_valid;
    assign wr_ok = wr_en && wr_addr < 32'(DEPTH);
    assign rdword = mem[addr];
    assign pop = fifo_valid & rd_ready;
    assign issue = state == RUN && (level < 2'(SKID_DEPTH) || pop);
    assign busy = state == RUN || state == DRAIN;
    assign done = state == FIN;
    assign rd_valid = fifo_valid;
    assign rd_last = fifo_valid & out_last;
    always_ff @(posedge clk) begin
        if (wr_ok)
            for (int i = 0; i < NB; i++)
                if (wr_be[i]) mem[wr_addr[AW-1:0]][8*i +: 8] <= wr_data[8*i +: 8];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            addr <= '0;
            len <= '0;
            issued <= '0;
        end else begin
            case (state)
                IDLE: if (burst_start) begin
                    addr <= burst_base;
                    len <= burst_len;
                    issued <= '0;
                    state <= burst_len == '0 ? FIN : RUN;
                end
                RUN: if (issue) begin
                    addr <= addr + 1'b1;
                    issued <= issued + 1'b1;
                    if (issued + 1'b1 == len) state <= DRAIN;
                end
                DRAIN: if (pop && out_last) state <= FIN;
                default: state <= IDLE;
            endcase
        end
    end
    // The FIFO register stage provides the single cycle of memory read latency.
    wmem_skid_fifo #(.W(WIDTH + 1)) u_skid (
        .clk(clk),
        .rst(rst),
        .push(issue),
        .din({issued == len - 1'b1, rdword}),
        .ready(rd_ready),
        .valid(fifo_valid),
        .dout({out_last, rd_data}),
        .level(level)
    );
`ifdef WMEM_PARITY_EN
    logic [NB-1:0] par [DEPTH];
    logic par_bad;
    always_ff @(posedge clk) begin
        if (wr_ok)
            for (int i = 0; i < NB; i++)
                if (wr_be[i]) par[wr_addr[AW-1:0]][i] <= byte_parity(wr_data[8*i +: 8]);
    end
    always_comb begin
        par_bad = 1'b0;
        for (int i = 0; i < NB; i++)
            par_bad = par_bad | (byte_parity(rdword[8*i +: 8]) != par[addr][i]);
    end
    always_ff @(posedge clk) begin
        if (rst) par_err <= 1'b0;
        else if (issue && par_bad) par_err <= 1'b1;
    end
`else
    assign par_err = 1'b0;
`endif
endmodule

// File: tb/tb_mem_weight_stream.sv
// tb_mem_weight_stream: randomized bursts checked against an array/queue reference model
module tb_mem_weight_stream;
    localparam int WIDTH = 64;
    localparam int DEPTH = 4096;
    localparam int AW = 12;
    localparam int LEN_W = 13;
    logic clk = 1'b0, rst = 1'b1;
    logic wr_en = 1'b0;
    logic [31:0] wr_addr = '0;
    logic [WIDTH-1:0] wr_data = '0;
    logic [7:0] wr_be = '0;
    logic burst_start = 1'b0;
    logic [AW-1:0] burst_base = '0;
    logic [LEN_W-1:0] burst_len = '0;
    logic busy, done, rd_valid, rd_last, par_err;
    logic rd_ready = 1'b0;
    logic [WIDTH-1:0] rd_data;
    logic [WIDTH-1:0] model [DEPTH];
    logic [WIDTH-1:0] first_word;
    int checks = 0, errors = 0;

    mem_weight_stream dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .burst_start(burst_start), .burst_base(burst_base),
        .burst_len(burst_len), .busy(busy), .done(done), .rd_valid(rd_valid),
        .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last), .par_err(par_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int unsigned a, input logic [63:0] d, input logic [7:0] be);
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = d;
        wr_be = be;
        if (a < DEPTH)
            for (int i = 0; i < 8; i++)
                if (be[i]) model[a][8*i +: 8] = d[8*i +: 8];
        tick;
        wr_en = 1'b0;
    endtask

    // mode 0: always ready with exact cycle timing, 1: alternating ready, 2: random ready
    task automatic run_burst(input int base, input int len, input int mode, input bit extra);
        logic [63:0] exp [$];
        logic [63:0] hd;
        logic hl;
        int beat;
        bit stall, got_done;
        for (int i = 0; i < len; i++) exp.push_back(model[(base + i) % DEPTH]);
        burst_base = AW'(base % DEPTH);
        burst_len = LEN_W'(len);
        burst_start = 1'b1;
        tick;
        burst_start = 1'b0;
        beat = 0;
        stall = 0;
        got_done = 0;
        hd = '0;
        hl = 1'b0;
        for (int cyc = 1; cyc < len * 8 + 20; cyc++) begin
            burst_start = extra && cyc == 3;
            if (extra && cyc == 3) burst_base = AW'($urandom);
            rd_ready = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 2 == 0) : ($urandom_range(0, 3) != 0);
            if (mode == 0) begin
                check("valid_timing", rd_valid, cyc >= 2 && cyc <= len + 1);
                check("done_timing", done, cyc == (len == 0 ? 1 : len + 2));
            end
            if (stall) begin
                check("hold_valid", rd_valid, 1);
                check("hold_data", rd_data, hd);
                check("hold_last", rd_last, hl);
            end
            if (rd_valid && rd_ready) begin
                if (beat < len) begin
                    check("data", rd_data, exp[beat]);
                    check("last", rd_last, beat == len - 1);
                    if (beat == 0) first_word = rd_data;
                end else check("overrun", beat + 1, len);
                beat++;
            end
            stall = rd_valid && !rd_ready;
            hd = rd_data;
            hl = rd_last;
            if (done) begin
                got_done = 1;
                break;
            end
            tick;
        end
        burst_start = 1'b0;
        check("done_seen", got_done, 1);
        check("beats", beat, len);
        check("busy_at_done", busy, 0);
        tick;
        check("done_once", done, 0);
        check("idle_valid", rd_valid, 0);
        check("idle_busy", busy, 0);
    endtask

    initial begin
        tick;
        tick;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", rd_valid, 0);
        check("rst_last", rd_last, 0);
        check("rst_data", rd_data, 0);
        check("rst_par", par_err, 0);
        rst = 1'b0;
        for (int a = 0; a < DEPTH; a++) wr(a, {$urandom, $urandom}, 8'hFF);
        for (int i = 0; i < 8; i++) wr(i, 64'h1111_0000_0000_0000 + 64'(i), 8'hFF);
        run_burst(0, 8, 0, 0);
        run_burst(0, 8, 1, 0);
        run_burst(DEPTH - 2, 4, 0, 0);
        run_burst(0, 0, 0, 0);
        run_burst(100, 10, 0, 1);
        wr(5, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        wr(5, 64'h0, 8'h0F);
        run_burst(5, 1, 0, 0);
        check("partial_write", first_word, 64'hFFFF_FFFF_0000_0000);
        wr(DEPTH, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF);
        run_burst(0, 1, 0, 0);
        check("oob_write_dropped", first_word, 64'h1111_0000_0000_0000);
        burst_base = 12'd40;
        burst_len = 13'd16;
        burst_start = 1'b1;
        rd_ready = 1'b1;
        tick;
        burst_start = 1'b0;
        for (int i = 0; i < 5; i++) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("abort_valid", rd_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        for (int i = 0; i < 3; i++) begin
            tick;
            check("abort_no_done", done, 0);
        end
        run_burst(40, 16, 2, 0);
        for (int n = 0; n < 25; n++) begin
            for (int k = $urandom_range(0, 3); k > 0; k--)
                wr($urandom_range(0, DEPTH + 50), {$urandom, $urandom}, 8'($urandom));
            run_burst($urandom_range(0, DEPTH - 1), $urandom_range(0, 24), 2, $urandom_range(0, 1) == 1);
        end
        check("par_err_clear", par_err, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
